rca_seq_ctrl: RTL and testbench
===============================

Name: rca_seq_ctrl

Overview:
- Multi-cycle sequencer that adds two WIDTH-bit operands by reusing one external 2-bit ripple carry adder slice, one slice per clock.
- Sits between a requester (start/done handshake) and a single rca instance.
- Drives the slice operands and carry-in, captures the slice sum and carry-out, and assembles the full-width result.
- The rca instance is combinational; its outputs return in the same cycle.

Parameters:
- WIDTH, 8, operand/result width; must be even and >= 2. SLICES = WIDTH/2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request pulse; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A, captured on accepted start.
- b  input  WIDTH  operand B, captured on accepted start.
- cin  input  1  initial carry-in, captured on accepted start.
- busy  output  1  high while slices are being processed (RUN).
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  assembled result; held until next accepted start.
- cout  output  1  final carry-out; held with sum.
- rca_a  output  2  current slice of A to the rca.
- rca_b  output  2  current slice of B to the rca.
- rca_cin  output  1  carry into the current slice.
- rca_sum  input  2  slice sum from the rca.
- rca_cout  input  1  slice carry-out from the rca.

Behaviour:
- One clock; reset is synchronous and active-low.
- When rst_n=0 at a clk edge:
  - state=IDLE, slice index=0.
  - busy=0, done=0, sum=0, cout=0, rca_a=0, rca_b=0, rca_cin=0.
  - Internal operand and carry registers are cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches a, b, cin; index<=0; carry_reg<=cin; sum<=0; cout<=0; go to RUN.
  - start=0 keeps IDLE.
- RUN:
  - busy=1.
  - rca_a=a_reg[2k+1:2k], rca_b=b_reg[2k+1:2k], rca_cin=carry_reg, where k is the index. All are decoded from registers only; no combinational path from start, a or b.
  - Each edge: sum[2k+1:2k]<=rca_sum; carry_reg<=rca_cout; index<=index+1.
  - At index=SLICES-1: cout<=rca_cout; go to DONE.
  - start is ignored.
- DONE:
  - done=1 for exactly this cycle; busy=0.
  - rca_a, rca_b and rca_cin are 0 in IDLE and DONE.
  - start=1 in DONE is accepted (back-to-back): same capture actions as IDLE, go to RUN. Otherwise go to IDLE.
- Latency:
  - start sampled at edge E0; busy high for SLICES cycles (E0..E_SLICES); done high for one cycle after E_SLICES.
  - WIDTH=8: 4 busy cycles, done in the 5th cycle.
- Width rules: the result is modulo 2^WIDTH; the carry out of the MSB slice goes to cout. The index counter is ceil(log2(SLICES)) bits, minimum 1, and never wraps past SLICES-1.
- Reset mid-operation aborts immediately: partial sum discarded, outputs at reset values, no done pulse.
- sum and cout are stable from done until the next accepted start.
- Operands changing while busy have no effect.

Optional Feature:
- Macro: RCA_SEQ_OVF_EN.
- Defined:
  - Extra output port ovf (1 bit), the signed two's-complement overflow of the full addition.
  - ovf = carry into MSB slice's top bit XOR final cout. Compute it as rca_a[1] ^ rca_b[1] ^ rca_sum[1], XORed with rca_cout, on the last slice.
  - Registered alongside cout and held with sum; reset value 0.
- Undefined: no ovf port and no associated logic.

Test Plan:
- WIDTH=8: a=0x00, b=0x00, cin=0, start pulse -> busy high 4 cycles, done pulse in the 5th cycle, sum=0x00, cout=0; rca_cin=0 on every slice.
- a=0x55, b=0xAA, cin=1 -> sum=0x00, cout=1; rca_cin sequence 1,1,1,1.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0x3C, b=0x0F, cin=0 -> sum=0x4B, cout=0.
- Start asserted during RUN with different operands -> ignored, result unchanged. Start held high in the DONE cycle -> new operation begins; busy reasserted the next cycle.
- rst_n=0 for one edge at slice index 2 -> busy=0, sum=0, cout=0, no done. A new start with a=0x10, b=0x20 then yields sum=0x30.
- With RCA_SEQ_OVF_EN: a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1; a=0xFF, b=0x01 -> ovf=0.

Source files
------------

// File: rtl/rca_seq_ctrl.sv
// rca_seq_ctrl: adds two WIDTH-bit operands over SLICES=WIDTH/2 clocks by
// reusing one external combinational 2-bit ripple-carry adder slice.
// Optional feature macro: RCA_SEQ_OVF_EN adds a registered signed-overflow
// output 'ovf'.
module rca_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [1:0]       rca_a,
  output logic [1:0]       rca_b,
  output logic             rca_cin,
  input  logic [1:0]       rca_sum,
  input  logic             rca_cout
`ifdef RCA_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int SLICES = WIDTH / 2;
  localparam int IW     = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [IW-1:0] LAST = IW'(SLICES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q, cout_q, busy_q, done_q;
`ifdef RCA_SEQ_OVF_EN
  logic             ovf_q;
  assign ovf = ovf_q;
`endif

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

  // Slice drive: decoded from captured operands and slice index only, so
  // nothing on the requester side can reach the adder combinationally.
  always_comb begin
    rca_a   = 2'b00;
    rca_b   = 2'b00;
    rca_cin = 1'b0;
    if (state_q == RUN) begin
      rca_a   = a_q[{idx_q, 1'b0} +: 2];
      rca_b   = b_q[{idx_q, 1'b0} +: 2];
      rca_cin = carry_q;
    end
  end

  // Sequencer FSM: capture on start, one slice per clock, pulse done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef RCA_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef RCA_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          sum_q[{idx_q, 1'b0} +: 2] <= rca_sum;
          carry_q <= rca_cout;
          if (idx_q == LAST) begin
            // Index parks on the last slice; the next accept clears it.
            cout_q  <= rca_cout;
`ifdef RCA_SEQ_OVF_EN
            // Carry into the MSB is recovered from the MSB's sum bit.
            ovf_q   <= rca_a[1] ^ rca_b[1] ^ rca_sum[1] ^ rca_cout;
`endif
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Self-checking bench for rca_seq_ctrl (WIDTH=8) with a behavioural 2-bit
// adder slice and an arithmetic reference model.
module tb_rca_seq_ctrl;

  localparam int W = 8;
  localparam int S = W / 2;

  logic         clk = 1'b0;
  logic         rst_n, start, cin;
  logic [W-1:0] a, b;
  logic         busy, done, cout;
  logic [W-1:0] sum;
  logic [1:0]   rca_a, rca_b, rca_sum;
  logic         rca_cin, rca_cout;
`ifdef RCA_SEQ_OVF_EN
  logic         ovf;
`endif

  int ntests = 0;
  int nfail  = 0;
  int exp_sum, exp_cout, exp_ovf;

  always #5 clk = ~clk;

  // External combinational adder slice.
  assign {rca_cout, rca_sum} = {1'b0, rca_a} + {1'b0, rca_b} + {2'b00, rca_cin};

  rca_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout),
    .rca_a(rca_a), .rca_b(rca_b), .rca_cin(rca_cin),
    .rca_sum(rca_sum), .rca_cout(rca_cout)
`ifdef RCA_SEQ_OVF_EN
    , .ovf(ovf)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full operation starting at the current negedge; inputs are
  // scrambled while busy to show they are ignored.
  task automatic op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc);
    int total, sa, sb, cin_k, lo;
    total = int'(oa) + int'(ob) + int'(oc);
    sa = (oa >= (1 << (W-1))) ? int'(oa) - (1 << W) : int'(oa);
    sb = (ob >= (1 << (W-1))) ? int'(ob) - (1 << W) : int'(ob);
    start = 1'b1; a = oa; b = ob; cin = oc;
    for (int k = 0; k < S; k++) begin
      @(negedge clk);
      lo    = 1 << (2*k);
      cin_k = ((int'(oa) % lo) + (int'(ob) % lo) + int'(oc)) / lo;
      chk("busy_run", busy, 1);
      chk("done_run", done, 0);
      chk("rca_a", rca_a, (int'(oa) / lo) % 4);
      chk("rca_b", rca_b, (int'(ob) / lo) % 4);
      chk("rca_cin", rca_cin, cin_k);
      start = 1'($urandom_range(0, 1));
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    end
    @(negedge clk);
    exp_sum  = total % (1 << W);
    exp_cout = total / (1 << W);
    exp_ovf  = ((sa + sb + int'(oc)) > (1 << (W-1)) - 1 ||
                (sa + sb + int'(oc)) < -(1 << (W-1))) ? 1 : 0;
    chk("busy_done", busy, 0);
    chk("done_pulse", done, 1);
    chk("sum", sum, exp_sum);
    chk("cout", cout, exp_cout);
    chk("rca_a_done", rca_a, 0);
    chk("rca_cin_done", rca_cin, 0);
`ifdef RCA_SEQ_OVF_EN
    chk("ovf", ovf, exp_ovf);
`endif
    start = 1'b0;
  endtask

  // One idle cycle: result must be held and the slice drive quiet.
  task automatic idle_chk();
    @(negedge clk);
    chk("busy_idle", busy, 0);
    chk("done_idle", done, 0);
    chk("sum_hold", sum, exp_sum);
    chk("cout_hold", cout, exp_cout);
    chk("rca_b_idle", rca_b, 0);
    chk("rca_cin_idle", rca_cin, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_rca_a", rca_a, 0);
    chk("rst_rca_cin", rca_cin, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases.
    op(8'h00, 8'h00, 1'b0); idle_chk();
    op(8'h55, 8'hAA, 1'b1); idle_chk();
    op(8'hFF, 8'h01, 1'b0); idle_chk();
    op(8'h3C, 8'h0F, 1'b0); idle_chk();
`ifdef RCA_SEQ_OVF_EN
    op(8'h7F, 8'h01, 1'b0); idle_chk();
    op(8'hFF, 8'h01, 1'b0); idle_chk();
    op(8'h80, 8'h80, 1'b0); idle_chk();
`endif

    // Back-to-back: start held in the DONE cycle.
    op(8'h12, 8'h34, 1'b0);
    op(8'hF0, 8'h0F, 1'b1);
    idle_chk();

    // Reset mid-operation at slice index 2.
    start = 1'b1; a = 8'hC3; b = 8'h5A; cin = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sum", sum, 0);
    chk("abort_cout", cout, 0);
    chk("abort_rca_a", rca_a, 0);
    @(negedge clk);
    chk("abort_no_done", done, 0);
    op(8'h10, 8'h20, 1'b0); idle_chk();

    // Random operations, some back-to-back.
    for (int i = 0; i < 24; i++) begin
      op(W'($urandom), W'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) != 0) idle_chk();
    end
    idle_chk();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
